// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg -- shared types and helpers for the ADC scan controller.
//   state_e        : scan FSM states
//   pick_t         : result of a set-bit search (found flag + bit index)
//   first_set_from : lowest set bit of a mask at or above a given index
package adc_scan_pkg;

  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CONVERT = 3'd2,
    WAIT    = 3'd3,
    EMIT    = 3'd4
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Priority encoder: lowest set bit with index >= from. Passing from = 0
  // gives the lowest set bit; from = cur+1 gives the next channel above cur.
  function automatic pick_t first_set_from(input logic [MAX_CH-1:0] mask,
                                           input int                from);
    pick_t p;
    p = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// adc_avg_accum -- per-channel sample accumulator and power-of-two divider.
//   clk, rst_n   : clock, async active-low reset
//   clr_i        : clear sum and sample count (start of a channel)
//   add_i        : accumulate sample_i and bump the sample count
//   sample_i     : ADC sample
//   last_o       : the sample being added now completes the set
//   avg_next_o   : (sum including sample_i) >> AVG_LOG2, truncating
module adc_avg_accum #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              last_o,
  output logic [DATA_W-1:0] avg_next_o
);

  // AVG_LOG2 extra bits hold 2^AVG_LOG2 full-scale samples without overflow.
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d, sum_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sum_next   = acc_q + ACC_W'(sample_i);
  assign avg_next_o = DATA_W'(sum_next >> AVG_LOG2);
  assign last_o     = (cnt_q == CNT_W'(NSAMP - 1));

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      acc_d = sum_next;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl -- scans enabled ADC channels, averages 2^AVG_LOG2 samples
// per channel and emits one result strobe per channel.
//   clk, reset_n          : clock, async active-low reset
//   start                 : launch a scan (ignored while busy or mask==0)
//   continuous            : rescan from the lowest channel at wrap while high
//   ch_mask               : channel enables, sampled at start and at wrap
//   clr_err               : clear sticky timeout_err
//   adc_convert/adc_ch_sel: conversion request and mux select to the ADC
//   adc_ready/adc_q       : conversion-done strobe and result
//   res_valid/res_ch/res_data : averaged result strobe, channel, value
//   busy                  : scan in progress
//   timeout_err           : sticky, set when the ADC fails to answer
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      clr_err,
  output logic                      adc_convert,
  output logic [$clog2(NUM_CH)-1:0] adc_ch_sel,
  input  logic                      adc_ready,
  input  logic [DATA_W-1:0]         adc_q,
  output logic                      res_valid,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [DATA_W-1:0]         res_data,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                err_q, err_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;

  logic                acc_clr, acc_add, acc_last, adv;
  logic [DATA_W-1:0]   avg_next;
  logic                live_nz;
  pick_t               nxt_p, live_p;

  adc_avg_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr_i      (acc_clr),
    .add_i      (acc_add),
    .sample_i   (adc_q),
    .last_o     (acc_last),
    .avg_next_o (avg_next)
  );

  assign live_nz = |ch_mask;

  // Next channel comes from the latched mask; the live mask only matters
  // at launch and at wrap.
  always_comb begin
    nxt_p  = first_set_from(MAX_CH'(mask_q), int'(ch_q) + 1);
    live_p = first_set_from(MAX_CH'(ch_mask), 0);
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ch_d       = ch_q;
    wcnt_d     = wcnt_q;
    err_d      = clr_err ? 1'b0 : err_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    adv        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && live_nz) begin
          mask_d  = ch_mask;
          ch_d    = CH_W'(live_p.idx);
          state_d = SELECT;
        end
      end
      SELECT: begin
        // Mux settle cycle; also drops any data from the previous channel.
        acc_clr = 1'b1;
        state_d = CONVERT;
      end
      CONVERT: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A ready arriving on the final wait cycle still counts.
        if (adc_ready) begin
          acc_add = 1'b1;
          if (acc_last) begin
            res_data_d = avg_next;
            res_ch_d   = ch_q;
            state_d    = EMIT;
          end else begin
            state_d = CONVERT;
          end
        end else if (wcnt_q == WC_LAST) begin
          // Set overrides a concurrent clr_err.
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      EMIT: adv = 1'b1;
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (nxt_p.found) begin
        ch_d    = CH_W'(nxt_p.idx);
        state_d = SELECT;
      end else if (continuous && live_nz) begin
        mask_d  = ch_mask;
        ch_d    = CH_W'(live_p.idx);
        state_d = SELECT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      ch_q       <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
    end
  end

  assign adc_convert = (state_q == CONVERT);
  assign adc_ch_sel  = ch_q;
  assign res_valid   = (state_q == EMIT);
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl -- directed + randomized bench for adc_scan_ctrl with a
// reactive ADC model and a per-channel averaging scoreboard.
module tb_adc_scan_ctrl;
  localparam int DW = 8, NCH = 4, CW = 2, NS = 4;

  logic clk = 1'b0;
  logic reset_n, start, continuous, clr_err, adc_ready;
  logic adc_convert, res_valid, busy, timeout_err;
  logic [NCH-1:0] ch_mask;
  logic [CW-1:0]  adc_ch_sel, res_ch;
  logic [DW-1:0]  adc_q, res_data;
  logic rsp_rdy, force_rdy;

  assign adc_ready = rsp_rdy | force_rdy;
  always #5 clk = ~clk;

  adc_scan_ctrl #(.DATA_W(DW), .NUM_CH(NCH), .AVG_LOG2(2), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .clr_err(clr_err), .adc_convert(adc_convert),
    .adc_ch_sel(adc_ch_sel), .adc_ready(adc_ready), .adc_q(adc_q),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .busy(busy), .timeout_err(timeout_err));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model and scoreboard state
  bit [NCH-1:0]  silent;
  bit            use_tbl;
  int            dly_min, dly_max;
  logic [DW-1:0] tbl [NCH][NS];
  int            tidx [NCH];
  int            m_sum [NCH];
  int            m_n [NCH];
  int            conv_cnt;
  int            exp_ch[$], exp_data[$];

  initial begin
    rsp_rdy = 1'b0;
    adc_q   = '0;
    forever begin
      @(negedge clk);
      rsp_rdy = 1'b0;
      if (reset_n && adc_convert) begin
        int ch, d;
        logic [DW-1:0] v;
        bit abort;
        ch = int'(adc_ch_sel);
        abort = 1'b0;
        conv_cnt++;
        if (!silent[ch]) begin
          d = $urandom_range(dly_max, dly_min);
          for (int k = 0; k < d; k++) begin
            @(negedge clk);
            if (!reset_n) abort = 1'b1;
          end
          if (!abort) begin
            v = use_tbl ? tbl[ch][tidx[ch]] : DW'($urandom);
            tidx[ch] = (tidx[ch] + 1) % NS;
            adc_q   = v;
            rsp_rdy = 1'b1;
            m_sum[ch] += int'(v);
            m_n[ch]++;
            if (m_n[ch] == NS) begin
              exp_ch.push_back(ch);
              exp_data.push_back(m_sum[ch] / NS);
              m_sum[ch] = 0;
              m_n[ch]   = 0;
            end
          end
        end
      end
    end
  end

  // Result monitor and timeout-latency observer
  int res_cnt = 0;
  int got_ch[$], got_data[$];
  int t0 = 0, tmo_lat = -1, err_rise = 0;
  logic err_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (res_valid) begin
      res_cnt++;
      got_ch.push_back(int'(res_ch));
      got_data.push_back(int'(res_data));
      chk("res_expected_pending", exp_ch.size() > 0, 1'b1);
      if (exp_ch.size() > 0) begin
        chk("res_ch_model", res_ch, exp_ch.pop_front());
        chk("res_data_model", res_data, exp_data.pop_front());
      end
    end
    if (adc_convert && silent[int'(adc_ch_sel)]) t0 = cyc;
    if (timeout_err && !err_prev) begin
      err_rise++;
      tmo_lat = cyc - t0;
    end
    err_prev = timeout_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k = 0;
    while (busy && k < maxc) begin @(negedge clk); k++; end
    chk(tag, k < maxc, 1'b1);
  endtask

  task automatic wait_res(input string tag, input int target, input int maxc);
    int k = 0;
    while (res_cnt < target && k < maxc) begin @(negedge clk); k++; end
    chk(tag, k < maxc, 1'b1);
  endtask

  task automatic wait_conv_ch(input string tag, input int ch, input int maxc);
    int k = 0;
    while (!(adc_convert && int'(adc_ch_sel) == ch) && k < maxc) begin @(negedge clk); k++; end
    chk(tag, k < maxc, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_convert"}, adc_convert, 0);
    chk({tag, "_ch_sel"},  adc_ch_sel, 0);
    chk({tag, "_valid"},   res_valid, 0);
    chk({tag, "_res_ch"},  res_ch, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_err"},     timeout_err, 0);
  endtask

  initial begin
    int base_res, base_conv, rise0, pop;
    logic [NCH-1:0] m;
    int order[$];

    reset_n = 1'b1; start = 0; continuous = 0; ch_mask = '0; clr_err = 0;
    force_rdy = 0; silent = '0; use_tbl = 0; dly_min = 1; dly_max = 4;
    conv_cnt = 0;
    for (int c = 0; c < NCH; c++) begin
      tidx[c] = 0; m_sum[c] = 0; m_n[c] = 0;
      for (int s = 0; s < NS; s++) tbl[c][s] = (c == 2) ? 8'hFF : 8'h00;
    end
    tbl[0][0] = 8'h10; tbl[0][1] = 8'h12; tbl[0][2] = 8'h14; tbl[0][3] = 8'h16;
    #1 reset_n = 1'b0;
    #11 chk_zero("rst");
    @(negedge clk) reset_n = 1'b1;
    cycles(2);

    // start with empty mask, ready strobes while idle
    ch_mask = '0;
    pulse_start();
    cycles(4);
    chk("zero_mask_busy", busy, 0);
    chk("zero_mask_conv", conv_cnt, 0);
    force_rdy = 1'b1; cycles(3); force_rdy = 1'b0; cycles(2);
    chk("idle_rdy_res", res_cnt, 0);
    chk("idle_rdy_busy", busy, 0);

    // two-channel scan with fixed ADC data, extra start while busy
    use_tbl = 1; ch_mask = 4'b0101;
    base_res = res_cnt; base_conv = conv_cnt; got_ch.delete(); got_data.delete();
    pulse_start();
    cycles(3);
    chk("scan_busy", busy, 1);
    ch_mask = 4'b1111; pulse_start(); ch_mask = 4'b0101;
    wait_idle("scan_idle", 2000);
    chk("scan_res_cnt", res_cnt - base_res, 2);
    chk("scan_conv_cnt", conv_cnt - base_conv, 8);
    if (got_ch.size() >= 2) begin
      chk("scan_r0_ch", got_ch[0], 0);
      chk("scan_r0_data", got_data[0], 32'h13);
      chk("scan_r1_ch", got_ch[1], 2);
      chk("scan_r1_data", got_data[1], 32'hFF);
    end
    cycles(3);
    chk("hold_res_ch", res_ch, 2);
    chk("hold_res_data", res_data, 8'hFF);
    chk("hold_valid", res_valid, 0);
    chk("no_err", timeout_err, 0);
    use_tbl = 0;

    // silent channel 1: timeout, no ch1 result
    silent = 4'b0010; ch_mask = 4'b0011;
    base_res = res_cnt; got_ch.delete(); got_data.delete();
    pulse_start();
    wait_idle("tmo_idle", 3000);
    chk("tmo_latency", tmo_lat, 256);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_res_cnt", res_cnt - base_res, 1);
    if (got_ch.size() >= 1) chk("tmo_r0_ch", got_ch[0], 0);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("clr_err", timeout_err, 0);

    // continuous with clr_err held: new timeouts still raise the flag
    continuous = 1; clr_err = 1; rise0 = err_rise;
    base_res = res_cnt; got_ch.delete(); got_data.delete();
    pulse_start();
    wait_res("cont_tmo_res", base_res + 2, 4000);
    continuous = 0;
    wait_idle("cont_tmo_idle", 3000);
    cycles(2);
    clr_err = 0;
    chk("cont_tmo_rise", err_rise > rise0, 1'b1);
    chk("cont_tmo_cleared", timeout_err, 0);
    foreach (got_ch[i]) chk("cont_tmo_ch0", got_ch[i], 0);
    silent = '0;

    // continuous with mask change mid-scan
    ch_mask = 4'b1000; continuous = 1;
    base_res = res_cnt; got_ch.delete(); got_data.delete();
    pulse_start();
    wait_conv_ch("mchg_conv3", 3, 100);
    ch_mask = 4'b0010;
    wait_res("mchg_res", base_res + 3, 4000);
    continuous = 0;
    wait_idle("mchg_idle", 2000);
    chk("mchg_cnt", got_ch.size() >= 3, 1'b1);
    if (got_ch.size() >= 1) chk("mchg_first_ch3", got_ch[0], 3);
    for (int i = 1; i < got_ch.size(); i++) chk("mchg_ch1", got_ch[i], 1);
    chk("mchg_sb_empty", exp_ch.size(), 0);

    // reset during WAIT
    ch_mask = 4'b0001; dly_min = 20; dly_max = 30;
    pulse_start();
    wait_conv_ch("rstw_conv", 0, 100);
    cycles(3);
    #2 reset_n = 1'b0;
    #1 chk_zero("rstw");
    cycles(2);
    reset_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin m_sum[c] = 0; m_n[c] = 0; tidx[c] = 0; end
    base_res = res_cnt; base_conv = conv_cnt;
    cycles(60);
    chk("rstw_no_res", res_cnt - base_res, 0);
    chk("rstw_no_conv", conv_cnt - base_conv, 0);
    chk("rstw_busy", busy, 0);
    dly_min = 1; dly_max = 6;

    // randomized single scans
    for (int it = 0; it < 6; it++) begin
      m = NCH'($urandom_range(15, 1));
      order.delete();
      for (int c = 0; c < NCH; c++) if (m[c]) order.push_back(c);
      pop = order.size();
      ch_mask = m;
      base_res = res_cnt; base_conv = conv_cnt; got_ch.delete(); got_data.delete();
      pulse_start();
      wait_idle("rnd_idle", 3000);
      chk("rnd_res_cnt", res_cnt - base_res, pop);
      chk("rnd_conv_cnt", conv_cnt - base_conv, NS * pop);
      for (int i = 0; i < got_ch.size() && i < pop; i++) chk("rnd_order", got_ch[i], order[i]);
      chk("rnd_sb_empty", exp_ch.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, ADC sample width.
REQ-002 The block SHALL have parameter NUM_CH, default 4, number of analog channels (2..16).
REQ-003 The block SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per channel (0..4).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, max cycles waited for adc_ready.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, chip clock; reset_n input 1, chip reset.
REQ-006 The block SHALL have ports: start  input  1  launch scan pulse.
REQ-007 continuous  input  1  rescan after last channel while high.
REQ-008 ch_mask  input  NUM_CH  channel enable mask.
REQ-009 clr_err  input  1  clears timeout_err.
REQ-010 adc_convert  output  1  one-cycle conversion request to ADC.
REQ-011 adc_ch_sel  output  $clog2(NUM_CH)  ADC mux select.
REQ-012 adc_ready  input  1  ADC conversion-done strobe.
REQ-013 adc_q  input  DATA_W  ADC result, valid with adc_ready.
REQ-014 res_valid  output  1  one-cycle result strobe; res_ch  output  $clog2(NUM_CH)  result channel; res_data  output  DATA_W  averaged result.
REQ-015 busy  output  1  high in every state except IDLE; timeout_err  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, SELECT, CONVERT, WAIT, EMIT.
REQ-017 IDLE: start=1 and ch_mask!=0 SHALL latch ch_mask into mask_q and go to SELECT with channel = lowest set bit; start with ch_mask=0 ignored.
REQ-018 SELECT SHALL drive adc_ch_sel = channel, clear accumulator and sample count, hold one settle cycle, then go to CONVERT.
REQ-019 CONVERT SHALL assert adc_convert for exactly one cycle, clear wait counter, go to WAIT.
REQ-020 WAIT: on adc_ready the block SHALL add adc_q to an accumulator of width DATA_W+AVG_LOG2 (no overflow possible) and increment sample count; if count reaches 2^AVG_LOG2 go to EMIT, else CONVERT.
REQ-021 WAIT: if wait counter reaches TIMEOUT without adc_ready, the block SHALL set timeout_err, discard the channel's partial data, and advance to the next channel without EMIT.
REQ-022 EMIT SHALL pulse res_valid one cycle with res_ch = channel and res_data = accumulator >> AVG_LOG2 (truncating).
REQ-023 Channel advance SHALL select the next set bit of mask_q above the current channel; adc_ch_sel remains stable from SELECT through end of EMIT/timeout.
REQ-024 At wrap (no higher set bit): if continuous=1 and live ch_mask!=0, relatch mask_q and go to SELECT on its lowest set bit; otherwise go to IDLE.
REQ-025 start while busy SHALL be ignored; ch_mask changes mid-scan SHALL take effect only at wrap.
REQ-026 adc_ready outside WAIT SHALL be ignored.
REQ-027 adc_ready and timeout in the same cycle: adc_ready SHALL win.
REQ-028 clr_err SHALL clear timeout_err; simultaneous new timeout SHALL win (flag stays set).
REQ-029 res_data, res_ch SHALL hold their last values until the next EMIT.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE and all outputs to 0 (adc_convert, adc_ch_sel, res_valid, res_ch, res_data, busy, timeout_err), clearing accumulator, counters and mask_q.
REQ-031 Reset mid-conversion SHALL abandon the scan; no res_valid after reset release until a new start.

Structure
REQ-032 FSM state enum and a priority-encoder helper function (next set bit above index) SHALL live in shared package adc_scan_pkg.
REQ-033 A single sub-module adc_avg_accum (accumulator, sample counter, shift divider) is natural; everything else in adc_scan_ctrl.

Verification
REQ-034 Defaults, ch_mask=4'b0101, start, ADC model returns 8'h10,8'h12,8'h14,8'h16 on ch0 and 8'hFF x4 on ch2 -> res_valid twice: (ch0, 8'h13), (ch2, 8'hFF); busy falls; exactly 8 adc_convert pulses.
REQ-035 ch_mask=4'b1000, continuous=1, mask changed to 4'b0010 mid-scan -> ch3 result, then ch1 results repeating; clear continuous -> IDLE after current ch1 EMIT.
REQ-036 ADC model silent on ch1, mask=4'b0011 -> timeout_err set after 255 wait cycles, no ch1 result, ch0 result emitted on next pass only if continuous; clr_err clears flag.
REQ-037 Assert reset_n low during WAIT -> all outputs 0 immediately, no res_valid after release without start.
REQ-038 start with ch_mask=0, and start pulses while busy -> no adc_convert, no state change; adc_ready pulses in IDLE -> no res_valid.
